des_sbox_stage: RTL and testbench
=================================

DES_SBOX_STAGE -- requirements
Module: des_sbox_stage

Interface
REQ-001 Parameters: none; all tables and widths are fixed by the DES standard.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  r_in/subkey valid.
REQ-005 in_ready  output  1  block accepts a new operand pair.
REQ-006 r_in  input  32  right half R(i-1); bit 31 = DES bit 1.
REQ-007 subkey  input  48  round key K(i); bit 47 = DES bit 1.
REQ-008 out_valid  output  1  s_out holds a finished result.
REQ-009 out_ready  input  1  consumer (P permutation stage) takes s_out.
REQ-010 s_out  output  32  S-box substitution result; bit 31 = DES bit 1.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be high only in IDLE.
REQ-013 On in_valid && in_ready, the block SHALL latch x = E(r_in) XOR subkey into a 48-bit register, clear the 3-bit box counter k, and enter RUN.
REQ-014 In RUN, each cycle SHALL evaluate box S(k+1) on x[47-6k -: 6] and write the result to s_out[31-4k -: 4]; bits not yet written SHALL hold their prior value.
REQ-015 S-box addressing: row = {chunk bit 5, chunk bit 0}; column = chunk bits 4:1 (chunk bit 5 = DES b1).
REQ-016 RUN SHALL exit to DONE after k == 7; out_valid SHALL rise exactly 8 clock edges after the acceptance edge.
REQ-017 In DONE, out_valid SHALL stay high and s_out SHALL remain stable until out_ready is sampled high; the state SHALL then return to IDLE, with out_valid low on the next cycle.
REQ-018 in_valid while not in IDLE SHALL be ignored; r_in and subkey changes after acceptance SHALL NOT affect the result.
REQ-019 The counter SHALL NOT wrap back into RUN; k == 7 always terminates RUN.
REQ-020 out_ready while not in DONE SHALL have no effect.

Reset
REQ-021 rst_n low SHALL, asynchronously and at any point including mid-RUN, force: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, s_out = 0, x = 0, k = 0.
REQ-022 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro DES_SBOX_PARALLEL_EN defined: RUN SHALL evaluate all 8 boxes in a single cycle; out_valid SHALL rise 2 edges after acceptance.
REQ-024 Macro DES_SBOX_PARALLEL_EN undefined: the serial single-LUT behaviour of REQ-014 and REQ-016 SHALL apply.
REQ-025 Handshake, reset values and results SHALL be identical in both builds; only latency differs.

Structure
REQ-026 Package des_pkg SHALL hold the E-expansion table, the eight S-box tables and the FSM state enum.
REQ-027 Sub-module des_sbox_lut (sel[2:0], in6[5:0] -> out4[3:0]) SHALL be a purely combinational lookup; the serial build SHALL use 1 instance and the parallel build 8.
REQ-028 s_out SHALL feed the existing 32-bit P permutation stage directly with no reordering.

Verification
REQ-029 r_in = 0xF0AAF0AA, subkey = 0x1B02EFFC7072 -> x = 0x6117BA866527, s_out = 0x5C82B597; downstream P output = 0x234AA9BB.
REQ-030 r_in = 0, subkey = 0 -> s_out = 0xEFA72C4D, with out_valid exactly 8 edges (serial) or 2 edges (parallel) after acceptance.
REQ-031 out_ready held low for 20 cycles in DONE -> out_valid stays 1 and s_out stays constant; in_ready stays 0; the first out_ready = 1 returns the FSM to IDLE.
REQ-032 Pulse rst_n low at k = 4 during RUN -> all outputs take reset values immediately (asynchronously); a fresh operand pair then completes correctly.
REQ-033 in_valid held high with changing r_in during RUN -> the result matches only the pair latched at acceptance; back-to-back operations give one result per handshake with none lost.

Source files
------------

// File: rtl/des_pkg.sv
// DES round tables (E expansion, S1..S8) and the S-box stage FSM encoding.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // DES bit numbers (1 = MSB) feeding each of the 48 expanded bits.
    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    // Each box is stored row-major: index = row * 16 + column.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [47:0] e_expand(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int i = 0; i < 48; i++) begin
            e[47 - i] = r[32 - E_TAB[i]];
        end
        return e;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One DES S-box lookup; sel picks S1..S8 (sel = 0 is S1).
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [5:0] in6,
    output logic [3:0] out4
);

    logic [5:0] idx;

    // Outer bits select the row, inner four bits the column.
    assign idx  = {in6[5], in6[0], in6[4:1]};
    assign out4 = 4'(SBOX[sel][idx]);

endmodule

// File: rtl/des_sbox_stage.sv
// DES round S-box substitution stage with valid/ready handshake.
// DES_SBOX_PARALLEL_EN: evaluate all eight boxes at once instead of one per cycle.
module des_sbox_stage
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s_out,
    output logic        busy
);

    state_t      state;
    logic [47:0] x;
    logic [2:0]  k;

`ifdef DES_SBOX_PARALLEL_EN
    logic [31:0] par_out;

    for (genvar g = 0; g < 8; g++) begin : g_box
        des_sbox_lut u_lut (
            .sel  (3'(g)),
            .in6  (x[47 - 6 * g -: 6]),
            .out4 (par_out[31 - 4 * g -: 4])
        );
    end
`else
    logic [5:0] chunk;
    logic [3:0] lut_out;

    always_comb begin
        chunk = x[47 - 6 * int'(k) -: 6];
    end

    des_sbox_lut u_lut (
        .sel  (k),
        .in6  (chunk),
        .out4 (lut_out)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            s_out     <= '0;
            x         <= '0;
            k         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= e_expand(r_in) ^ subkey;
                        k        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
`ifdef DES_SBOX_PARALLEL_EN
                    // Parks k at 7 so the second RUN cycle exits.
                    s_out <= par_out;
                    k     <= 3'd7;
`else
                    s_out[31 - 4 * int'(k) -: 4] <= lut_out;
                    if (k != 3'd7) begin
                        k <= k + 3'd1;
                    end
`endif
                    if (k == 3'd7) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_sbox_stage.sv
// Directed-vector bench for des_sbox_stage.
module tb_des_sbox_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r_in;
    logic [47:0] subkey;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s_out;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DES_SBOX_PARALLEL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 8;
`endif

    des_sbox_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_in      (r_in),
        .subkey    (subkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] r,
                          input logic [47:0] key, input logic [31:0] exp,
                          input int hold, input bit churn);
        int          n;
        logic [31:0] snap;
        bit          stable;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        r_in     = r;
        subkey   = key;
        tick();
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
        if (!churn) in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (churn) begin
                r_in      = r_in ^ 32'hDEAD_BEEF ^ 32'(n);
                subkey    = {16'(n), $urandom()};
                out_ready = 1'b1;
            end
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_s_out"}, 64'(s_out), 64'(exp));
        snap   = s_out;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!out_valid || in_ready || s_out !== snap) stable = 1'b0;
        end
        if (hold > 0) begin
            chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
            chk({tag, "_hold_s_out"}, 64'(s_out), 64'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_low"}, 64'(out_valid), 64'd0);
        chk({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        r_in      = '0;
        subkey    = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_out", 64'(s_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;

        run_op("fips", 32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h5C82B597, 0, 1'b0);
        run_op("zero", 32'h0, 48'h0, 32'hEFA72C4D, 20, 1'b0);
        run_op("ones", 32'hFFFFFFFF, 48'h0, 32'hD9CE3DCB, 0, 1'b0);
        run_op("key1", 32'h0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 0, 1'b0);
        run_op("nokey", 32'hF0AAF0AA, 48'h0, 32'h7D529456, 0, 1'b0);

        run_op("churn_a", 32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h5C82B597, 0, 1'b1);
        run_op("churn_b", 32'h0, 48'h0, 32'hEFA72C4D, 0, 1'b1);
        in_valid = 1'b0;

        in_valid = 1'b1;
        r_in     = 32'hF0AAF0AA;
        subkey   = 48'h1B02EFFC7072;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_s_out", 64'(s_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        run_op("after_rst", 32'h0, 48'h0, 32'hEFA72C4D, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
